// File: rtl/hex_request_decoder.sv
// Parses ASCII register requests ("R<4 hex>\r" / "W<4 hex><4 hex>\r") from a UART byte stream.
// Optional macro LOWERCASE_HEX_EN also accepts 'a'-'f' as hex digits.
module hex_request_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o,
  output logic        rw_o,
  output logic        valid_o,
  output logic        err_o
);

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    EOL
  } state_t;

  state_t      state_reg;
  logic [2:0]  digit_cnt_reg;
  logic [31:0] acc_reg;
  logic        rw_reg;

  logic        is_hex;
  logic [3:0]  nibble;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      is_hex = 1'b1;
      nibble = data_i[3:0];
    end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
      is_hex = 1'b1;
      nibble = data_i[3:0] + 4'd9;
    end
`ifdef LOWERCASE_HEX_EN
    else if (data_i >= 8'h61 && data_i <= 8'h66) begin
      is_hex = 1'b1;
      nibble = data_i[3:0] + 4'd9;
    end
`endif
  end

  // The bus read-data field is unused on the request path.
  assign rdata_o = 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      digit_cnt_reg <= 3'd0;
      acc_reg       <= 32'd0;
      rw_reg        <= 1'b0;
      addr_o        <= 16'h0000;
      wdata_o       <= 16'h0000;
      rw_o          <= 1'b0;
      valid_o       <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (valid_i) begin
        case (state_reg)
          IDLE: begin
            digit_cnt_reg <= 3'd0;
            acc_reg       <= 32'd0;
            if (data_i == CHAR_R) begin
              state_reg <= ADDR;
              rw_reg    <= 1'b0;
            end else if (data_i == CHAR_W) begin
              state_reg <= ADDR;
              rw_reg    <= 1'b1;
            end else if (data_i != CHAR_CR && data_i != CHAR_LF) begin
              err_o <= 1'b1;
            end
          end
          ADDR, DATA: begin
            if (is_hex) begin
              acc_reg <= {acc_reg[27:0], nibble};
              if (digit_cnt_reg == 3'd3) begin
                digit_cnt_reg <= 3'd0;
                state_reg     <= (state_reg == ADDR && rw_reg) ? DATA : EOL;
              end else begin
                digit_cnt_reg <= digit_cnt_reg + 3'd1;
              end
            end else begin
              err_o         <= 1'b1;
              state_reg     <= IDLE;
              digit_cnt_reg <= 3'd0;
              acc_reg       <= 32'd0;
              rw_reg        <= 1'b0;
            end
          end
          EOL: begin
            // Writes hold addr in the upper half of the accumulator, reads in the lower half.
            if (data_i == CHAR_CR) begin
              valid_o <= 1'b1;
              rw_o    <= rw_reg;
              if (rw_reg) begin
                addr_o  <= acc_reg[31:16];
                wdata_o <= acc_reg[15:0];
              end else begin
                addr_o  <= acc_reg[15:0];
                wdata_o <= 16'h0000;
              end
            end else begin
              err_o <= 1'b1;
            end
            state_reg     <= IDLE;
            digit_cnt_reg <= 3'd0;
            acc_reg       <= 32'd0;
            rw_reg        <= 1'b0;
          end
          default: begin
            state_reg     <= IDLE;
            digit_cnt_reg <= 3'd0;
            acc_reg       <= 32'd0;
            rw_reg        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_request_decoder.sv
// Self-checking bench for hex_request_decoder: directed messages plus randomized streams
// compared against a message-level reference model.
module tb_hex_request_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata_o;
  logic        rw_o;
  logic        valid_o;
  logic        err_o;

  hex_request_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_o (rdata_o),
    .rw_o    (rw_o),
    .valid_o (valid_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    bit          is_err;
    bit          is_valid;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [7:0]  msg[$];
  int          neg_cnt = 0;
  int          rdata_bad = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  logic        last_rw = 1'b0;

  // Monitor: every strobe observed is stamped with the falling-edge index it was seen on.
  always @(negedge clk) begin
    ev_t e;
    neg_cnt <= neg_cnt + 1;
    if (valid_o === 1'b1 || err_o === 1'b1) begin
      e.stamp    = neg_cnt + 1;
      e.is_err   = (err_o === 1'b1);
      e.is_valid = (valid_o === 1'b1);
      e.addr     = addr_o;
      e.wdata    = wdata_o;
      e.rw       = rw_o;
      obs_q.push_back(e);
    end
    if (rst === 1'b0 && rdata_o !== 16'h0000) rdata_bad <= rdata_bad + 1;
  end

  function automatic bit tb_is_hex(input logic [7:0] b);
`ifdef LOWERCASE_HEX_EN
    if (b >= "a" && b <= "f") return 1'b1;
`endif
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F");
  endfunction

  function automatic logic [3:0] tb_val(input logic [7:0] b);
    if (b <= "9") return 4'(b - 8'h30);
    if (b <= "F") return 4'(b - 8'h37);
    return 4'(b - 8'h57);
  endfunction

  // Reference model: a message is collected whole, then judged against its expected length.
  task automatic model_byte(input logic [7:0] b, input int stamp);
    ev_t e;
    int  len;
    e.stamp = stamp; e.is_err = 1'b0; e.is_valid = 1'b0;
    e.addr = 16'h0; e.wdata = 16'h0; e.rw = 1'b0;
    if (msg.size() == 0) begin
      if (b == "R" || b == "W") msg.push_back(b);
      else if (b != 8'h0D && b != 8'h0A) begin e.is_err = 1'b1; exp_q.push_back(e); end
    end else begin
      len = (msg[0] == "W") ? 10 : 6;
      if (msg.size() == len - 1) begin
        if (b == 8'h0D) begin
          e.is_valid = 1'b1;
          e.rw = (msg[0] == "W");
          for (int k = 1; k <= 4; k++) e.addr = e.addr * 16 + 16'(tb_val(msg[k]));
          if (e.rw) for (int k = 5; k <= 8; k++) e.wdata = e.wdata * 16 + 16'(tb_val(msg[k]));
          last_addr = e.addr; last_wdata = e.wdata; last_rw = e.rw;
        end else begin
          e.is_err = 1'b1;
        end
        exp_q.push_back(e);
        msg.delete();
      end else if (tb_is_hex(b)) begin
        msg.push_back(b);
      end else begin
        e.is_err = 1'b1;
        exp_q.push_back(e);
        msg.delete();
      end
    end
  endtask

  // All driving happens 1 time unit after a falling edge.
  task automatic send_q(input logic [7:0] q[$], input int max_gap);
    for (int i = 0; i < q.size(); i++) begin
      int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        @(negedge clk); #1;
      end
      data_i  = q[i];
      valid_i = 1'b1;
      model_byte(q[i], neg_cnt + 1);
      @(negedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic send_str(input string s, input int max_gap);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_q(q, max_gap);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_reset(input logic [7:0] b);
    rst = 1'b1; valid_i = 1'b1; data_i = b;
    @(negedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    msg.delete();
  endtask

  task automatic start_scenario();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; data_i = "R";
    repeat (2) begin @(negedge clk); #1; end
    checks++;
    if ({addr_o, wdata_o, rdata_o, rw_o, valid_o, err_o} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h rdata=%h rw=%b v=%b e=%b expected all zero",
               addr_o, wdata_o, rdata_o, rw_o, valid_o, err_o);
    end
    rst = 1'b0; valid_i = 1'b0;
    msg.delete();
    start_scenario();
    // The 'R' presented during reset must be lost, so these digits are malformed.
    send_str("0001\r", 0);
    idle(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL reset_byte_discard: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].stamp !== exp_q[i].stamp || obs_q[i].is_err !== exp_q[i].is_err ||
          obs_q[i].is_valid !== exp_q[i].is_valid) begin
        errors++;
        $display("FAIL reset_event%0d: got t=%0d err=%b val=%b expected t=%0d err=%b val=%b", i,
                 obs_q[i].stamp, obs_q[i].is_err, obs_q[i].is_valid,
                 exp_q[i].stamp, exp_q[i].is_err, exp_q[i].is_valid);
      end
    end
    $display("reset: %0d strobes after reset-time byte", obs_q.size());
  endtask

  task automatic test_directed();
    start_scenario();
    send_str("R0001\r", 1);
    idle(2);
    checks++;
    if ({addr_o, wdata_o, rw_o} !== {16'h0001, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL read_0001: got addr=%h wdata=%h rw=%b expected 0001 0000 0", addr_o, wdata_o, rw_o);
    end
    send_str("W00080006\r\n", 2);
    idle(2);
    checks++;
    if ({addr_o, wdata_o, rw_o} !== {16'h0008, 16'h0006, 1'b1}) begin
      errors++;
      $display("FAIL write_0008: got addr=%h wdata=%h rw=%b expected 0008 0006 1", addr_o, wdata_o, rw_o);
    end
    send_str("R00G1\r", 0);
    idle(2);
    checks++;
    if ({addr_o, wdata_o, rw_o} !== {16'h0008, 16'h0006, 1'b1}) begin
      errors++;
      $display("FAIL hold_after_err: got addr=%h wdata=%h rw=%b expected 0008 0006 1", addr_o, wdata_o, rw_o);
    end
    send_str("R0003\r", 0);
    idle(2);
    checks++;
    if ({addr_o, wdata_o, rw_o} !== {16'h0003, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL read_after_err: got addr=%h wdata=%h rw=%b expected 0003 0000 0", addr_o, wdata_o, rw_o);
    end
    send_str("W12", 0);
    pulse_reset("3");
    send_str("R0009\r", 1);
    idle(2);
    checks++;
    if (addr_o !== 16'h0009) begin
      errors++;
      $display("FAIL reset_mid_msg: got addr=%h expected 0009", addr_o);
    end
    send_str("R00ab\r", 0);
    idle(2);
    checks++;
`ifdef LOWERCASE_HEX_EN
    if (addr_o !== 16'h00AB) begin
      errors++;
      $display("FAIL lowercase_hex: got addr=%h expected 00ab", addr_o);
    end
`else
    if (addr_o !== 16'h0009) begin
      errors++;
      $display("FAIL lowercase_hex: got addr=%h expected 0009 (held)", addr_o);
    end
`endif
    send_str("RW\r", 0);
    idle(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL directed_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].stamp !== exp_q[i].stamp || obs_q[i].is_err !== exp_q[i].is_err ||
          obs_q[i].is_valid !== exp_q[i].is_valid ||
          (exp_q[i].is_valid && {obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw} !==
                                {exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw})) begin
        errors++;
        $display("FAIL directed_event%0d: got t=%0d err=%b val=%b a=%h d=%h rw=%b expected t=%0d err=%b val=%b a=%h d=%h rw=%b",
                 i, obs_q[i].stamp, obs_q[i].is_err, obs_q[i].is_valid, obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw,
                 exp_q[i].stamp, exp_q[i].is_err, exp_q[i].is_valid, exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw);
      end else begin
        $display("directed event%0d t=%0d err=%b val=%b addr=%h wdata=%h rw=%b", i, obs_q[i].stamp,
                 obs_q[i].is_err, obs_q[i].is_valid, obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_scenario();
    send_str("W1234FFBB\r", 0);
    send_str("R0002\r", 0);
    idle(3);
    checks++;
    if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes expected 2", obs_q.size());
    end
    // The read's CR is accepted six byte-cycles after the write's CR.
    checks++;
    if (obs_q.size() >= 2 && (obs_q[1].stamp - obs_q[0].stamp) !== 6) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles expected 6", obs_q[1].stamp - obs_q[0].stamp);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].stamp !== exp_q[i].stamp || obs_q[i].is_err !== exp_q[i].is_err ||
          obs_q[i].is_valid !== exp_q[i].is_valid ||
          {obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw} !== {exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw}) begin
        errors++;
        $display("FAIL b2b_event%0d: got t=%0d a=%h d=%h rw=%b expected t=%0d a=%h d=%h rw=%b", i,
                 obs_q[i].stamp, obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw,
                 exp_q[i].stamp, exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw);
      end else begin
        $display("b2b event%0d t=%0d addr=%h wdata=%h rw=%b", i, obs_q[i].stamp,
                 obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw);
      end
    end
    checks++;
    if ({exp_q[1].addr, exp_q[0].wdata} !== {16'h0002, 16'hFFBB}) begin
      errors++;
      $display("FAIL b2b_model_fields: got a=%h d=%h expected 0002 ffbb", exp_q[1].addr, exp_q[0].wdata);
    end
  endtask

  task automatic test_random();
    string hexchars = "0123456789ABCDEFabcdef";
    start_scenario();
    for (int m = 0; m < 150; m++) begin
      logic [7:0] q[$];
      int kind = $urandom_range(0, 5);
      int ndig;
      q.push_back(kind < 3 ? "W" : (kind < 5 ? "R" : 8'($urandom)));
      ndig = (q[0] == "W") ? 8 : 4;
      for (int d = 0; d < ndig; d++) q.push_back(hexchars[$urandom_range(0, 15 + 6 * ($urandom_range(0, 9) == 0))]);
      if ($urandom_range(0, 7) == 0) q[$urandom_range(1, ndig)] = 8'($urandom);
      q.push_back($urandom_range(0, 9) == 0 ? 8'($urandom) : 8'h0D);
      if ($urandom_range(0, 3) == 0) q.push_back(8'h0A);
      if ($urandom_range(0, 9) == 0) void'(q.pop_back());
      send_q(q, $urandom_range(0, 2));
    end
    idle(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].stamp !== exp_q[i].stamp || obs_q[i].is_err !== exp_q[i].is_err ||
          obs_q[i].is_valid !== exp_q[i].is_valid ||
          (exp_q[i].is_valid && {obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw} !==
                                {exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw})) begin
        errors++;
        $display("FAIL random_event%0d: got t=%0d err=%b val=%b a=%h d=%h rw=%b expected t=%0d err=%b val=%b a=%h d=%h rw=%b",
                 i, obs_q[i].stamp, obs_q[i].is_err, obs_q[i].is_valid, obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw,
                 exp_q[i].stamp, exp_q[i].is_err, exp_q[i].is_valid, exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw);
      end else begin
        $display("random event%0d t=%0d err=%b val=%b addr=%h wdata=%h rw=%b", i, obs_q[i].stamp,
                 obs_q[i].is_err, obs_q[i].is_valid, obs_q[i].addr, obs_q[i].wdata, obs_q[i].rw);
      end
    end
    checks++;
    if ({addr_o, wdata_o, rw_o} !== {last_addr, last_wdata, last_rw}) begin
      errors++;
      $display("FAIL random_hold: got a=%h d=%h rw=%b expected a=%h d=%h rw=%b",
               addr_o, wdata_o, rw_o, last_addr, last_wdata, last_rw);
    end
    checks++;
    if (rdata_bad !== 0) begin
      errors++;
      $display("FAIL rdata_zero: got %0d nonzero cycles expected 0", rdata_bad);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = 8'h00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
